cpu_core_param: RTL
===================

Name: cpu_core_param

Overview:
Parametrised multi-cycle CPU core, the next generation of the 8-bit single-cycle cpu. Adds configurable data width and register count, and an instruction-memory request/valid handshake. Adds ALU flags, conditional branches on flags and gpi, a CALL/RET return stack with fault detection, and a HALT state. It sits between the instruction ROM/turbo controller and the board I/O (din, gpi, dout, gout).

Parameters:
DATA_W, 8, datapath and register width (4..16).
NUM_REGS, 16, register-file depth (power of 2, 2..256); register index = low $clog2(NUM_REGS) bits of an arg field.
ADDR_W, 8, program-counter width (1..8); address field = instruction[ADDR_W-1:0].
STACK_DEPTH, 4, return-stack entries (1..16).

Ports:
clk  in  1  system clock.
resetn  in  1  reset; asynchronous, active-low.
enable  in  1  step gate (turbo); sampled only in FETCH.
imem_addr  out  ADDR_W  fetch address; equals pc.
imem_req  out  1  fetch request.
imem_valid  in  1  instruction valid; instruction is captured in the cycle it is high while imem_req=1.
instruction  in  32  [31:29] group, [28:26] cmd, [23:16] arg1, [15:8] arg2, [7:0] address.
din  in  DATA_W  data input.
gpi  in  4  general-purpose inputs.
dout  out  DATA_W  output register.
gout  out  8  general-purpose output register.
flags  out  4  {fault, N, C, Z}.
halted  out  1  high in HALT state.

Behaviour:
- Reset: pc, dout, gout, flags, all registers and stack pointer = 0; halted=0; state=FETCH. Reset mid-fetch drops imem_req immediately (async).
- States:
  - FETCH: imem_req=0 unless enable=1. With enable=1: imem_req=1; if imem_valid=1, latch IR and go to EXEC; else go to WAIT.
  - WAIT: imem_req=1 (enable ignored); on imem_valid=1 latch IR and go to EXEC.
  - EXEC: one cycle; apply the instruction; go to FETCH, or to HALT.
  - HALT: imem_req=0, halted=1; leaves only on reset.
- Minimum 2 cycles per instruction. All architectural updates occur at the EXEC clock edge.
- Default next pc = pc+1, wrapping modulo 2^ADDR_W.
- Operand naming: rd = arg2 index, rs = arg1 index, imm = arg1 zero-extended or truncated to DATA_W.
- Groups:
  - 0 NOP.
  - 1 ALU reg: rd <= rd op R[rs].
  - 2 ALU imm: rd <= rd op imm.
  - 3 BRANCH: if the condition holds, pc <= address. cmd 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 gpi[arg1[1:0]]=1, 7 gpi[arg1[1:0]]=0.
  - 4 CALL: push pc+1, pc <= address. If the stack is full: no push, fault=1, go to HALT.
  - 5 RET: pop into pc. If the stack is empty: fault=1, go to HALT.
  - 6 IO: cmd 0 rd <= din; cmd 1 dout <= R[rs]; cmd 2 gout <= arg1; other cmds NOP.
  - 7 HALT.
- ALU cmd: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR by 1 (logical), 7 MOV (rd <= operand).
- Flags, updated by groups 1/2 only:
  - Z = (result==0); N = result[DATA_W-1].
  - C by op: ADD carry-out; SUB borrow (1 if rd < operand, unsigned); SHL old msb; SHR old lsb.
  - Logic ops clear C; MOV leaves C unchanged.
- fault is sticky until reset.
- Same-register case: rs==rd is legal; the read uses the pre-edge value.
- A register read in EXEC sees all prior EXEC writes (no hazards in a multi-cycle design).
- Stack: pointer counts 0..STACK_DEPTH. CALL at depth STACK_DEPTH-1 succeeds; the next CALL faults.

Test Plan:
1. Reset, enable=1, imem_valid tied 1: ALU imm MOV r1,5; ADD r1,3 -> r1=8, Z=0, C=0; one instruction every 2 cycles; pc=2.
2. DATA_W=8: MOV r2,0xFF; ADD r2,1 -> r2=0x00, Z=1, C=1. Then BRANCH cmd1 addr 0x20 -> pc=0x20.
3. imem_valid delayed 3 cycles -> imem_req held high 4 cycles, imem_addr stable, IR captured only on valid. enable=0 in FETCH -> pc frozen, imem_req=0.
4. STACK_DEPTH=2: CALL, CALL succeed; RET returns to the inner pc+1. A third nested CALL -> fault=1, halted=1, pc unchanged, no further imem_req.
5. RET at empty stack after reset -> fault=1, halted=1. Assert resetn low mid-WAIT -> all outputs 0 asynchronously; execution restarts at pc=0.
6. din=0x3C: IN r4; OUT r4 -> dout=0x3C. gout cmd arg1=0x81 -> gout=0x81. gpi=4'b0100 with BRANCH cmd6 arg1=2 -> taken; cmd7 -> not taken.

Source files
------------

// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: FETCH/WAIT/EXEC/HALT sequencer with an imem
// request/valid handshake, a flag-setting ALU, conditional branches and a return stack.
module cpu_core_param #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        gpi,
  output logic [DATA_W-1:0] dout,
  output logic [7:0]        gout,
  output logic [3:0]        flags,
  output logic              halted
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int STK_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] G_ALU_REG = 3'd1;
  localparam logic [2:0] G_ALU_IMM = 3'd2;
  localparam logic [2:0] G_BRANCH  = 3'd3;
  localparam logic [2:0] G_CALL    = 3'd4;
  localparam logic [2:0] G_RET     = 3'd5;
  localparam logic [2:0] G_IO      = 3'd6;
  localparam logic [2:0] G_HALT    = 3'd7;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
  state_t state, state_next;

  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc, pc_inc, pc_next;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_dec;
  logic              fault, flag_n, flag_c, flag_z;

  logic [2:0]        grp, cmd;
  logic [IDX_W-1:0]  rd_idx, rs_idx;
  logic [DATA_W-1:0] rd_val, rs_val, imm, operand, alu_res;
  logic [DATA_W:0]   sum;
  logic              alu_c, stack_full, stack_empty, branch_taken, trap;
  logic              unused_ir;

  assign grp         = ir[31:29];
  assign cmd         = ir[28:26];
  assign rs_idx      = ir[16 +: IDX_W];
  assign rd_idx      = ir[8 +: IDX_W];
  assign imm         = DATA_W'(ir[23:16]);
  assign rd_val      = regs[rd_idx];
  assign rs_val      = regs[rs_idx];
  assign operand     = (grp == G_ALU_REG) ? rs_val : imm;
  assign pc_inc      = pc + ADDR_W'(1);
  assign sp_dec      = sp - SP_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign trap        = (grp == G_HALT) || (grp == G_CALL && stack_full) ||
                       (grp == G_RET && stack_empty);
  assign unused_ir   = ^{ir[25:24], ir[23:16], ir[15:8], ir[7:0]};

  assign imem_addr = pc;
  assign flags     = {fault, flag_n, flag_c, flag_z};

  always_comb begin
    sum     = {1'b0, rd_val} + {1'b0, operand};
    alu_res = operand;
    alu_c   = flag_c;
    case (cmd)
      3'd0: begin alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
      3'd1: begin alu_res = rd_val - operand; alu_c = (rd_val < operand); end
      3'd2: begin alu_res = rd_val & operand; alu_c = 1'b0; end
      3'd3: begin alu_res = rd_val | operand; alu_c = 1'b0; end
      3'd4: begin alu_res = rd_val ^ operand; alu_c = 1'b0; end
      3'd5: begin alu_res = {rd_val[DATA_W-2:0], 1'b0}; alu_c = rd_val[DATA_W-1]; end
      3'd6: begin alu_res = {1'b0, rd_val[DATA_W-1:1]}; alu_c = rd_val[0]; end
      default: ;
    endcase
  end

  always_comb begin
    case (cmd)
      3'd0:    branch_taken = 1'b1;
      3'd1:    branch_taken = flag_z;
      3'd2:    branch_taken = !flag_z;
      3'd3:    branch_taken = flag_c;
      3'd4:    branch_taken = !flag_c;
      3'd5:    branch_taken = flag_n;
      3'd6:    branch_taken = gpi[ir[17:16]];
      default: branch_taken = !gpi[ir[17:16]];
    endcase
  end

  // A faulting CALL/RET or HALT leaves pc on the offending instruction.
  always_comb begin
    pc_next = pc_inc;
    case (grp)
      G_BRANCH: if (branch_taken) pc_next = ir[ADDR_W-1:0];
      G_CALL:   pc_next = stack_full ? pc : ir[ADDR_W-1:0];
      G_RET:    pc_next = stack_empty ? pc : stack[sp_dec[STK_W-1:0]];
      G_HALT:   pc_next = pc;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (enable) state_next = imem_valid ? S_EXEC : S_WAIT;
      S_WAIT:  if (imem_valid) state_next = S_EXEC;
      S_EXEC:  state_next = trap ? S_HALT : S_FETCH;
      default: state_next = S_HALT;
    endcase
  end

  // Request is gated by resetn so it drops the instant reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: imem_req = enable & resetn;
      S_WAIT:  imem_req = resetn;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir     <= '0;
      pc     <= '0;
      sp     <= '0;
      dout   <= '0;
      gout   <= '0;
      fault  <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      if (imem_req && imem_valid) ir <= instruction;
      if (state == S_EXEC) begin
        pc <= pc_next;
        case (grp)
          G_ALU_REG, G_ALU_IMM: begin
            regs[rd_idx] <= alu_res;
            flag_z       <= (alu_res == '0);
            flag_n       <= alu_res[DATA_W-1];
            flag_c       <= alu_c;
          end
          G_CALL: begin
            if (stack_full) begin
              fault <= 1'b1;
            end else begin
              stack[sp[STK_W-1:0]] <= pc_inc;
              sp <= sp + SP_W'(1);
            end
          end
          G_RET: begin
            if (stack_empty) fault <= 1'b1;
            else             sp <= sp_dec;
          end
          G_IO: begin
            case (cmd)
              3'd0:    regs[rd_idx] <= din;
              3'd1:    dout <= rs_val;
              3'd2:    gout <= ir[23:16];
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
